// File: rtl/spi_slave_pkg.sv
// Shared types and defaults for the SPI slave data path.
package spi_slave_pkg;

    localparam int unsigned SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } spi_state_e;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI slave RX/TX shift registers with RX valid/ready holding register and TX holding register.
// Define SPI_LSB_FIRST_EN for LSB-first shifting; MSB-first otherwise.
module spi_slave_shifter
    import spi_slave_pkg::*;
#(
    parameter int unsigned N = SPI_DATA_W
) (
    input  logic         clk_c,
    input  logic         reset_rn,
    input  logic         cs_ni,
    input  logic         mosi_i,
    input  logic         last_bit_i,
    input  logic [N-1:0] tx_data_i,
    input  logic         tx_load_i,
    output logic         tx_full_o,
    output logic         miso_o,
    output logic [N-1:0] rx_data_o,
    output logic         rx_valid_o,
    input  logic         rx_ready_i,
    input  logic         ovr_clr_i,
    output logic         overrun_o
);

    spi_state_e   state;
    logic [N-1:0] rx_shift;
    logic [N-1:0] tx_shift;
    logic [N-1:0] tx_hold;

    logic [N-1:0] rx_next;
    logic [N-1:0] tx_next;
    logic [N-1:0] tx_preload;
    logic         terminal;
    logic         shift_edge;
    logic         byte_start;
    logic         tx_accept;

    assign terminal   = !cs_ni && (state == SHIFT) && last_bit_i;
    assign shift_edge = !cs_ni && !terminal;
    assign byte_start = shift_edge && (state != SHIFT);
    // A byte start consumes the held TX byte, which frees the slot for a same-edge load.
    assign tx_accept  = tx_load_i && (!tx_full_o || byte_start);
    assign tx_preload = tx_full_o ? tx_hold : '0;

`ifdef SPI_LSB_FIRST_EN
    assign rx_next = {mosi_i, rx_shift[N-1:1]};
    assign tx_next = tx_shift >> 1;
    assign miso_o  = tx_shift[0];
`else
    assign rx_next = {rx_shift[N-2:0], mosi_i};
    assign tx_next = tx_shift << 1;
    assign miso_o  = tx_shift[N-1];
`endif

    always_ff @(posedge clk_c or negedge reset_rn) begin
        if (!reset_rn) begin
            state      <= IDLE;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            tx_full_o  <= 1'b0;
            rx_data_o  <= '0;
            rx_valid_o <= 1'b0;
            overrun_o  <= 1'b0;
        end else begin
            if (tx_accept) begin
                tx_hold   <= tx_data_i;
                tx_full_o <= 1'b1;
            end else if (byte_start) begin
                tx_full_o <= 1'b0;
            end

            if (cs_ni) begin
                state    <= IDLE;
                rx_shift <= '0;
                tx_shift <= tx_preload;
            end else if (terminal) begin
                state    <= DONE;
                tx_shift <= tx_preload;
            end else begin
                state    <= SHIFT;
                rx_shift <= rx_next;
                tx_shift <= tx_next;
            end

            if (terminal) begin
                if (!rx_valid_o || rx_ready_i) begin
                    rx_data_o  <= rx_shift;
                    rx_valid_o <= 1'b1;
                end
            end else if (rx_ready_i) begin
                rx_valid_o <= 1'b0;
            end

            // A dropped byte sets the flag even when a clear arrives on the same edge.
            if (terminal && rx_valid_o && !rx_ready_i) begin
                overrun_o <= 1'b1;
            end else if (ovr_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_shifter.sv
// Self-checking bench for spi_slave_shifter: vector table, corner sequences, randomized frames.
module tb_spi_slave_shifter;

    localparam int unsigned N = 8;

    logic         clk_c;
    logic         reset_rn;
    logic         cs_ni;
    logic         mosi_i;
    logic         last_bit_i;
    logic [N-1:0] tx_data_i;
    logic         tx_load_i;
    logic         tx_full_o;
    logic         miso_o;
    logic [N-1:0] rx_data_o;
    logic         rx_valid_o;
    logic         rx_ready_i;
    logic         ovr_clr_i;
    logic         overrun_o;

    spi_slave_shifter #(.N(N)) dut (
        .clk_c      (clk_c),
        .reset_rn   (reset_rn),
        .cs_ni      (cs_ni),
        .mosi_i     (mosi_i),
        .last_bit_i (last_bit_i),
        .tx_data_i  (tx_data_i),
        .tx_load_i  (tx_load_i),
        .tx_full_o  (tx_full_o),
        .miso_o     (miso_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_ready_i (rx_ready_i),
        .ovr_clr_i  (ovr_clr_i),
        .overrun_o  (overrun_o)
    );

    initial clk_c = 1'b0;
    always #5 clk_c = ~clk_c;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic       clr;
        logic       consume;
        logic       load;
        logic [7:0] tx;
        logic [7:0] mosi;
        logic       ready;
        logic [7:0] exp_rx;
        logic       exp_v;
        logic       exp_ovr;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_c);
        #1;
    endtask

    // Position within the byte of the i-th bit on the wire.
    function automatic int bit_pos(input int i);
`ifdef SPI_LSB_FIRST_EN
        return i;
`else
        return 7 - i;
`endif
    endfunction

    task automatic idle(input int n);
        cs_ni = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic load(input logic [7:0] d);
        cs_ni     = 1'b1;
        tx_load_i = 1'b1;
        tx_data_i = d;
        tick();
        tx_load_i = 1'b0;
    endtask

    task automatic consume();
        cs_ni      = 1'b1;
        rx_ready_i = 1'b1;
        tick();
        rx_ready_i = 1'b0;
    endtask

    task automatic clear_ovr();
        cs_ni     = 1'b1;
        ovr_clr_i = 1'b1;
        tick();
        ovr_clr_i = 1'b0;
    endtask

    // N shift edges then one terminal edge; cs stays low afterwards.
    task automatic run_frame(input logic [7:0] mosi_byte, input logic ready_term, input logic clr_term,
                             input logic load_start, input logic [7:0] load_data,
                             output logic [7:0] miso_got, output logic full_after_first);
        logic [7:0] mb;
        mb       = mosi_byte;
        miso_got = '0;
        full_after_first = 1'b0;
        cs_ni    = 1'b0;
        for (int i = 0; i < 8; i++) begin
            mosi_i = mb[bit_pos(i)];
            miso_got[bit_pos(i)] = miso_o;
            if (i == 0 && load_start) begin
                tx_load_i = 1'b1;
                tx_data_i = load_data;
            end
            tick();
            tx_load_i = 1'b0;
            if (i == 0) full_after_first = tx_full_o;
        end
        last_bit_i = 1'b1;
        rx_ready_i = ready_term;
        ovr_clr_i  = clr_term;
        tick();
        last_bit_i = 1'b0;
        rx_ready_i = 1'b0;
        ovr_clr_i  = 1'b0;
        mosi_i     = 1'b0;
    endtask

    task automatic do_reset();
        reset_rn = 1'b0;
        cs_ni    = 1'b1;
        tick();
        tick();
        reset_rn = 1'b1;
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] g;
    logic       f;
    logic [7:0] pat;

    // Frame-level reference state
    logic       m_valid, m_ovr, m_full;
    logic [7:0] m_data, m_hold, exp_tx;
    logic [7:0] r_mosi, r_ld, r_d;
    logic       r_ready, r_ls;

    initial begin
        reset_rn   = 1'b0;
        cs_ni      = 1'b1;
        mosi_i     = 1'b0;
        last_bit_i = 1'b0;
        tx_data_i  = '0;
        tx_load_i  = 1'b0;
        rx_ready_i = 1'b0;
        ovr_clr_i  = 1'b0;
        #2;
        check("rst_rx_data", rx_data_o, 0);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_overrun", overrun_o, 0);
        check("rst_tx_full", tx_full_o, 0);
        check("rst_miso", miso_o, 0);
        tick();
        reset_rn = 1'b1;
        idle(2);

        // Basic frame: TX 0xA5, RX 0x3C
        load(8'hA5);
        check("load_full", tx_full_o, 1);
        idle(1);
        run_frame(8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        check("basic_miso", g, 8'hA5);
        check("basic_full_first", f, 0);
        check("basic_rx", rx_data_o, 8'h3C);
        check("basic_valid", rx_valid_o, 1);
        idle(1);
        consume();
        check("consume_valid", rx_valid_o, 0);

        // Back-to-back frames without accept -> overrun, first byte kept
        run_frame(8'h11, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        run_frame(8'h22, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        idle(1);
        check("b2b_rx", rx_data_o, 8'h11);
        check("b2b_ovr", overrun_o, 1);
        clear_ovr();
        check("ovr_clear", overrun_o, 0);

        // Terminal edge with accept while holding 0x11
        run_frame(8'h22, 1'b1, 1'b0, 1'b0, 8'h00, g, f);
        idle(1);
        check("accept_rx", rx_data_o, 8'h22);
        check("accept_valid", rx_valid_o, 1);
        check("accept_ovr", overrun_o, 0);

        // Overrun set and clear on same edge: set wins
        run_frame(8'h33, 1'b0, 1'b1, 1'b0, 8'h00, g, f);
        idle(1);
        check("setwins_ovr", overrun_o, 1);
        check("setwins_rx", rx_data_o, 8'h22);
        clear_ovr();

        // Aborted frame after 4 bits, then a full 0xF0 frame
        consume();
        cs_ni  = 1'b0;
        mosi_i = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        idle(1);
        check("abort_valid", rx_valid_o, 0);
        check("abort_rx", rx_data_o, 8'h22);
        run_frame(8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        idle(1);
        check("abort_next_rx", rx_data_o, 8'hF0);
        check("abort_next_valid", rx_valid_o, 1);

        // TX underrun, ignored load while full, load on byte-start edge
        consume();
        run_frame(8'h69, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        idle(1);
        check("underrun_miso", g, 8'h00);
        load(8'h5A);
        idle(1);
        load(8'h77);
        idle(1);
        run_frame(8'h12, 1'b0, 1'b0, 1'b1, 8'hC3, g, f);
        check("start_load_full", f, 1);
        check("start_load_miso", g, 8'h5A);
        idle(1);
        check("start_load_full_after", tx_full_o, 1);
        run_frame(8'h34, 1'b0, 1'b0, 1'b0, 8'h00, g, f);
        check("reload_miso", g, 8'hC3);
        check("reload_full_first", f, 0);
        idle(1);

        // Vector table: clr, consume, load, tx, mosi, ready, exp_rx, exp_v, exp_ovr, exp_miso
        clear_ovr();
        consume();
        tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h81, 8'h96, 1'b0, 8'h96, 1'b1, 1'b0, 8'h81};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00};
        tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h7E, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b1, 8'h7E};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 8'h01, 8'h80, 1'b0, 8'h80, 1'b1, 1'b1, 8'h01};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8'h00};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 8'hFE, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'hFE};
        for (int i = 0; i < 6; i++) begin
            if (tbl[i].clr) clear_ovr();
            if (tbl[i].consume) consume();
            if (tbl[i].load) load(tbl[i].tx);
            idle(1);
            run_frame(tbl[i].mosi, tbl[i].ready, 1'b0, 1'b0, 8'h00, g, f);
            idle(1);
            check($sformatf("tbl%0d_miso", i), g, tbl[i].exp_miso);
            check($sformatf("tbl%0d_rx", i), rx_data_o, tbl[i].exp_rx);
            check($sformatf("tbl%0d_valid", i), rx_valid_o, tbl[i].exp_v);
            check($sformatf("tbl%0d_ovr", i), overrun_o, tbl[i].exp_ovr);
            check($sformatf("tbl%0d_full", i), tx_full_o, 0);
        end

        // Asynchronous reset in the middle of a frame
        run_frame(8'hAB, 1'b1, 1'b0, 1'b0, 8'h00, g, f);
        idle(1);
        load(8'hFF);
        idle(1);
        load(8'h55);
        cs_ni  = 1'b0;
        mosi_i = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check("pre_rst_miso", miso_o, 1);
        #2;
        reset_rn = 1'b0;
        #1;
        check("async_rx_data", rx_data_o, 0);
        check("async_valid", rx_valid_o, 0);
        check("async_full", tx_full_o, 0);
        check("async_miso", miso_o, 0);
        check("async_ovr", overrun_o, 0);
        cs_ni  = 1'b1;
        mosi_i = 1'b0;
        tick();
        reset_rn = 1'b1;
        tick();

        // Randomized frames against a frame-level model
        m_valid = 1'b0; m_ovr = 1'b0; m_full = 1'b0; m_data = '0; m_hold = '0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                consume();
                m_valid = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) begin
                clear_ovr();
                m_ovr = 1'b0;
            end
            if ($urandom_range(0, 1) == 1) begin
                r_d = 8'($urandom);
                load(r_d);
                if (!m_full) begin
                    m_hold = r_d;
                    m_full = 1'b1;
                end
            end
            idle(1);
            exp_tx  = m_full ? m_hold : 8'h00;
            r_mosi  = 8'($urandom);
            r_ready = 1'($urandom_range(0, 1));
            r_ls    = ($urandom_range(0, 3) == 0);
            r_ld    = 8'($urandom);
            run_frame(r_mosi, r_ready, 1'b0, r_ls, r_ld, g, f);
            if (r_ls) begin
                m_hold = r_ld;
                m_full = 1'b1;
            end else begin
                m_full = 1'b0;
            end
            if (!m_valid || r_ready) begin
                m_data  = r_mosi;
                m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
            idle(1);
            check($sformatf("rnd%0d_miso", it), g, exp_tx);
            check($sformatf("rnd%0d_rx", it), rx_data_o, m_data);
            check($sformatf("rnd%0d_valid", it), rx_valid_o, m_valid);
            check($sformatf("rnd%0d_ovr", it), overrun_o, m_ovr);
            check($sformatf("rnd%0d_full", it), tx_full_o, m_full);
        end

        pat = 8'h00;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_shifter.md
Name: spi_slave_shifter

Overview:
- Data-path stage directly downstream of the SPI slave bit counter.
- Samples MOSI into a receive shift register while the counter runs; on the counter's terminal cycle, transfers the assembled byte to a holding register with valid/ready handshake.
- In parallel, shifts a preloaded transmit byte out on MISO.
- Same SPI clock domain as the bit counter.

Parameters:
- N, 8, data width of one frame (bits shifted per byte).

Ports:
- clk_c  in  1  SPI clock; all state updates on rising edge.
- reset_rn  in  1  asynchronous active-low reset.
- cs_ni  in  1  chip select, active-low; same net as the bit counter's enable.
- mosi_i  in  1  serial data in.
- last_bit_i  in  1  bit counter terminal flag; high during the cycle after the Nth data edge.
- tx_data_i  in  N  byte to transmit next.
- tx_load_i  in  1  write tx_data_i into the TX holding register.
- tx_full_o  out  1  TX holding register occupied.
- miso_o  out  1  serial data out; combinational from the TX shift register bit.
- rx_data_o  out  N  last received byte.
- rx_valid_o  out  1  rx_data_o holds an unread byte.
- rx_ready_i  in  1  consumer accepts rx_data_o.
- ovr_clr_i  in  1  clear overrun flag.
- overrun_o  out  1  sticky: byte completed while rx_valid_o high and not accepted.

Behaviour:
- Reset (reset_rn low, async): state IDLE; rx_shift, tx_shift, tx_hold and rx_data_o = 0; tx_full_o, rx_valid_o, overrun_o = 0; miso_o = 0.
- States: IDLE, SHIFT, DONE.
  - IDLE: cs_ni high. Any state goes to IDLE on an edge with cs_ni high; last_bit_i is ignored.
  - IDLE/DONE, cs_ni low, last_bit_i low: shift edge, go to SHIFT.
  - SHIFT, cs_ni low, last_bit_i low: shift edge, stay in SHIFT.
  - SHIFT, cs_ni low, last_bit_i high: terminal edge, go to DONE.
- Shift edge:
  - rx_shift <= {rx_shift[N-2:0], mosi_i}.
  - tx_shift <= tx_shift << 1.
  - miso_o = tx_shift[N-1].
- Byte start: the first shift edge taken from IDLE or DONE. It clears tx_full_o (byte consumed) unless tx_load_i is high the same edge; in that case the new data is stored and tx_full_o stays 1.
- TX preload:
  - In IDLE, every edge: tx_shift <= tx_full_o ? tx_hold : 0.
  - At a terminal edge: same reload rule.
  - If TX is empty, 0x00 is shifted out (underrun; not flagged).
- tx_load_i: accepted only when tx_full_o = 0 or at a byte-start edge; ignored otherwise. tx_hold <= tx_data_i, tx_full_o <= 1.
- Terminal edge, RX:
  - If rx_valid_o = 0 or rx_ready_i = 1: rx_data_o <= rx_shift, rx_valid_o <= 1.
  - Otherwise: new byte dropped, rx_data_o unchanged, overrun_o <= 1.
- Handshake: rx_valid_o && rx_ready_i on an edge with no terminal event clears rx_valid_o. Terminal edge plus accept on the same edge: new byte loaded, rx_valid_o stays 1, no overrun.
- overrun_o: cleared by ovr_clr_i. If set and clear occur on the same edge, set wins.
- Latency: rx_valid_o rises one edge after the Nth data edge (on the terminal edge).
- cs_ni rising mid-byte: partial rx_shift is discarded (cleared to 0); rx_data_o, rx_valid_o and tx_hold are unaffected. The next frame restarts at bit 0.
- Back-to-back bytes: DONE behaves as IDLE for byte start. Each frame is N shift edges plus 1 terminal edge.

Optional Feature:
- SPI_LSB_FIRST_EN defined:
  - rx_shift <= {mosi_i, rx_shift[N-1:1]}.
  - tx shifts right.
  - miso_o = tx_shift[0].
- Undefined: MSB-first, as described above.

Decomposition:
- Package spi_slave_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - localparam SPI_DATA_W = 8, default for N.
- No sub-module. The bit counter is instantiated alongside at the parent level, and its last output drives last_bit_i.

Test Plan:
- Reset, then tx_load 0xA5, cs low, 8 shift edges with MOSI = 0x3C MSB-first, terminal edge -> MISO bits 1,0,1,0,0,1,0,1; rx_data_o = 0x3C; rx_valid_o = 1; tx_full_o = 0 after the first edge.
- Two back-to-back frames 0x11 then 0x22, rx_ready_i held 0 -> rx_data_o = 0x11, overrun_o = 1; ovr_clr_i pulse clears it.
- Terminal edge coincident with rx_ready_i = 1 while holding 0x11 -> rx_data_o = 0x22, rx_valid_o = 1, overrun_o = 0.
- cs_ni high after 4 bits, then full frame 0xF0 -> rx_data_o = 0xF0; no stale bits.
- No tx_load before frame -> MISO = 0 for all 8 bits. tx_load on the byte-start edge -> tx_full_o stays 1.
- reset_rn low mid-frame asynchronously -> all outputs 0 immediately; with SPI_LSB_FIRST_EN, MOSI 0x3C sent LSB-first yields 0x3C.
